// File: rtl/period_pkg.sv
// period_pkg: limits and state encoding shared by the period generator and measurement blocks
package period_pkg;
  localparam int PERIOD_W = 14;
  localparam int MAX_PERIOD = 10000;
  localparam int MIN_PERIOD = 2;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/period_clamp.sv
// period_clamp: clamps a requested (period, high) pair into the legal range
module period_clamp #(
  parameter int MIN_P = period_pkg::MIN_PERIOD,
  parameter int MAX_P = period_pkg::MAX_PERIOD
) (
  input  logic [period_pkg::PERIOD_W-1:0] i_period,
  input  logic [period_pkg::PERIOD_W-1:0] i_high,
  output logic [period_pkg::PERIOD_W-1:0] o_period,
  output logic [period_pkg::PERIOD_W-1:0] o_high
);
  import period_pkg::*;
  localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(MIN_P);
  localparam logic [PERIOD_W-1:0] P_MAX = PERIOD_W'(MAX_P);
  logic [PERIOD_W-1:0] w_lo;
  always_comb begin
    w_lo = i_period < P_MIN ? P_MIN : i_period;
    o_period = w_lo > P_MAX ? P_MAX : w_lo;
    o_high = i_high > o_period ? o_period : i_high;
  end
endmodule

// File: rtl/period_generator.sv
// period_generator: double-buffered programmable square-wave generator
module period_generator #(
  parameter int MAX_PERIOD = period_pkg::MAX_PERIOD,
  parameter int MIN_PERIOD = period_pkg::MIN_PERIOD
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic                            iCE,
  input  logic                            iRun,
  input  logic                            iLoad,
  input  logic [period_pkg::PERIOD_W-1:0] iPeriod,
  input  logic [period_pkg::PERIOD_W-1:0] iHigh,
  output logic                            oSignal,
  output logic                            oWrap,
  output logic                            oBusy,
  output logic                            oPending
);
  import period_pkg::*;
  state_t r_state, w_state_nx;
  logic [PERIOD_W-1:0] r_cnt, r_per, r_high, r_pper, r_phigh;
  logic [PERIOD_W-1:0] w_cp, w_ch, w_cnt_nx, w_per_nx, w_high_nx;
  logic r_pend, r_sig, r_wrap;
  logic w_end, w_apply_new, w_stash, w_sig_nx, w_pend_nx;
  period_clamp #(.MIN_P(MIN_PERIOD), .MAX_P(MAX_PERIOD)) u_clamp (
    .i_period(iPeriod),
    .i_high  (iHigh),
    .o_period(w_cp),
    .o_high  (w_ch)
  );
  // A load landing on the boundary tick wins over any older pending pair
  always_comb begin
    w_end = r_state == RUN && iCE && r_cnt == r_per - 1'b1;
    w_apply_new = iLoad && (r_state == IDLE || w_end);
    w_stash = iLoad && r_state == RUN && !w_end;
    w_state_nx = r_state == IDLE ? (iRun ? RUN : IDLE) : (w_end && !iRun ? IDLE : RUN);
    w_per_nx = w_apply_new ? w_cp : (w_end && r_pend) ? r_pper : r_per;
    w_high_nx = w_apply_new ? w_ch : (w_end && r_pend) ? r_phigh : r_high;
    w_cnt_nx = (r_state == IDLE || w_end) ? '0 : iCE ? r_cnt + 1'b1 : r_cnt;
    w_sig_nx = w_state_nx == IDLE ? 1'b0 : (r_state == IDLE || iCE) ? w_cnt_nx < w_high_nx : r_sig;
    w_pend_nx = w_stash ? 1'b1 : w_end ? 1'b0 : r_pend;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_per <= PERIOD_W'(MAX_PERIOD);
      r_high <= '0;
      r_pper <= '0;
      r_phigh <= '0;
      r_pend <= 1'b0;
      r_sig <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_per <= w_per_nx;
      r_high <= w_high_nx;
      r_pend <= w_pend_nx;
      r_sig <= w_sig_nx;
      r_wrap <= w_end;
      if (w_stash) begin
        r_pper <= w_cp;
        r_phigh <= w_ch;
      end
    end
  end
  assign oSignal = r_sig;
  assign oWrap = r_wrap;
  assign oBusy = r_state == RUN;
  assign oPending = r_pend;
endmodule

// File: tb/tb_period_generator.sv
// tb_period_generator: randomized and directed check of period_generator against a tick-level model
module tb_period_generator;
  logic iClk = 0, iRst = 1, iCE = 0, iRun = 0, iLoad = 0;
  logic [13:0] iPeriod = 0, iHigh = 0;
  logic oSignal, oWrap, oBusy, oPending;
  int n_chk = 0, n_pass = 0;
  int m_busy, m_pos, m_p, m_h, m_pp, m_ph, m_pend, m_sig, m_wrap;
  period_generator dut (
    .iClk(iClk), .iRst(iRst), .iCE(iCE), .iRun(iRun), .iLoad(iLoad),
    .iPeriod(iPeriod), .iHigh(iHigh),
    .oSignal(oSignal), .oWrap(oWrap), .oBusy(oBusy), .oPending(oPending)
  );
  always #5 iClk = ~iClk;
  function automatic int clamp_p(int p);
    return p < 2 ? 2 : (p > 10000 ? 10000 : p);
  endfunction
  function automatic int clamp_h(int h, int p);
    return h > p ? p : h;
  endfunction
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s t=%0t got %0d expected %0d", tag, $time, got, exp);
  endtask
  // Model tracks position within the period and the period/high pairs as plain integers
  task automatic model_edge();
    int np, nh;
    np = clamp_p(int'(iPeriod));
    nh = clamp_h(int'(iHigh), np);
    m_wrap = 0;
    if (iRst) begin
      m_busy = 0; m_pos = 0; m_p = 10000; m_h = 0; m_pend = 0; m_sig = 0;
    end else if (!m_busy) begin
      if (iLoad) begin m_p = np; m_h = nh; end
      m_busy = iRun ? 1 : 0;
      m_pos = 0;
      m_sig = (iRun && m_h > 0) ? 1 : 0;
    end else if (iCE && m_pos + 1 == m_p) begin
      if (iLoad) begin m_p = np; m_h = nh; end
      else if (m_pend) begin m_p = m_pp; m_h = m_ph; end
      m_pend = 0;
      m_pos = 0;
      m_wrap = 1;
      m_busy = iRun ? 1 : 0;
      m_sig = (iRun && m_h > 0) ? 1 : 0;
    end else begin
      if (iCE) begin m_pos++; m_sig = m_pos < m_h ? 1 : 0; end
      if (iLoad) begin m_pp = np; m_ph = nh; m_pend = 1; end
    end
  endtask
  task automatic cyc();
    @(posedge iClk);
    model_edge();
    #1;
    check("signal", int'(oSignal), m_sig);
    check("wrap", int'(oWrap), m_wrap);
    check("busy", int'(oBusy), m_busy);
    check("pending", int'(oPending), m_pend);
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic load(int p, int h);
    iLoad = 1; iPeriod = 14'(p); iHigh = 14'(h);
    cyc();
    iLoad = 0;
  endtask
  initial begin
    m_busy = 0; m_pos = 0; m_p = 10000; m_h = 0; m_pp = 0; m_ph = 0;
    m_pend = 0; m_sig = 0; m_wrap = 0;
    run(3);
    iRst = 0;
    run(2);
    load(4, 1);
    iRun = 1; iCE = 1;
    run(13);
    load(10, 5);
    run(12);
    load(6, 3);
    run(4);
    load(7, 2);
    run(30);
    load(0, 9);
    run(10);
    load(12000, 5000);
    run(10010);
    load(8, 4);
    for (int i = 0; i < 40; i++) begin iCE = i[0] == 0; cyc(); end
    iCE = 1;
    load(6, 2);
    run(8);
    iRun = 0;
    run(10);
    iRun = 1;
    load(10, 5);
    run(13);
    load(20, 3);
    iRst = 1;
    cyc();
    iRst = 0;
    run(10);
    for (int i = 0; i < 4000; i++) begin
      iCE = $urandom_range(0, 3) != 0;
      iRun = $urandom_range(0, 19) != 0;
      iLoad = $urandom_range(0, 9) == 0;
      iPeriod = $urandom_range(0, 31) == 0 ? 14'($urandom_range(0, 16383)) : 14'($urandom_range(0, 24));
      iHigh = 14'($urandom_range(0, 26));
      iRst = $urandom_range(0, 299) == 0;
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/period_generator.md
# period_generator

Programmable square-wave generator: produces an output signal with a period and high time given in enabled clock ticks. It is the transmit-side counterpart of the period-measurement block; the block drives test signals whose period the measurement path reads back. Period range and saturation limits match the measurement side: 14-bit counts, saturating at 10000. Parameter updates are double-buffered and take effect only at period boundaries, so the output never glitches.

## Interface
- MAX_PERIOD, 10000: upper clamp for period (ticks); matches measurement saturation.
- MIN_PERIOD, 2: lower clamp for period (ticks).
- iClk  in  1  system clock; all logic on rising edge.
- iRst  in  1  reset, synchronous and active-high.
- iCE  in  1  tick enable; counters advance only when 1.
- iRun  in  1  level; 1 = generate, 0 = stop at end of current period.
- iLoad  in  1  one-clock strobe; captures iPeriod/iHigh into pending registers.
- iPeriod  in  14  requested period in ticks.
- iHigh  in  14  requested high time in ticks.
- oSignal  out  1  generated waveform, registered.
- oWrap  out  1  one-clock pulse the cycle after the tick that completes a period.
- oBusy  out  1  1 while not IDLE.
- oPending  out  1  1 while a loaded pair waits to be applied.

## Operation
- Reset values:
  - state IDLE.
  - oSignal = 0, oWrap = 0, oBusy = 0, oPending = 0.
  - active period = MAX_PERIOD, active high = 0.
  - tick counter = 0.
- Clamping is applied on capture:
  - P = min(max(iPeriod, MIN_PERIOD), MAX_PERIOD).
  - H = min(iHigh, P).
  - H = 0 gives constant low while running; H = P gives constant high.
- States:
  - IDLE: oSignal = 0, counter held at 0.
    - iRun = 1 (any iCE) → RUN at the next edge. Counter = 0, oSignal = (0 < H).
  - RUN: on each iCE = 1 cycle, counter increments.
    - At counter = P−1 the counter wraps to 0, the period ends, and oWrap fires next cycle.
    - oSignal = (counter_next < H), updated only on ticks.
    - At a period end with iRun = 0 → IDLE. oSignal = 0, oBusy = 0 next cycle.
  - iRun deasserted mid-period: the period completes fully; no truncation.
- Load:
  - iLoad in IDLE: the pair becomes active immediately; oPending stays 0.
  - iLoad in RUN: the pair goes into pending registers and oPending = 1. The pair is applied at the next period end; oPending clears in the same edge.
  - iLoad coinciding with a period-ending tick: the new pair applies to the period starting at that boundary; oPending never asserts.
  - Repeated iLoad before a boundary: last write wins.
- iRst mid-operation: all state returns to reset values at that edge. Pending data is discarded.

## Timing
- Start latency: iRun sampled high at edge t → oBusy = 1 and first oSignal value at t+1.
- With iCE held at 1: oSignal is high exactly H cycles and low P−H cycles per period. Period = P cycles exactly.
- iCE = 0 freezes the counter and oSignal. oWrap is not generated on non-tick cycles.
- oWrap: high exactly one clock, at edge t+1 after the wrap tick at t.
- No combinational path from any input to any output.

## Structure
- Shared package `period_pkg`:
  - PERIOD_W = 14, MAX_PERIOD = 10000, MIN_PERIOD = 2.
  - State encoding IDLE/RUN.
  - Shared with the measurement block so both ends agree on limits.
- Sub-module `period_clamp`: combinational clamp of (iPeriod, iHigh) → (P, H). Instantiated once at the capture point.
- Top holds the FSM, counter, active/pending registers and output registers.

## Test plan
- Reset, then iLoad P = 4, H = 1 in IDLE, iRun = 1, iCE = 1 → oSignal 1,0,0,0 repeating from t+1. oWrap every 4 cycles.
- Running P = 10, H = 5; iLoad P = 6, H = 3 mid-period → oPending = 1 until the boundary. The current period stays 10 cycles; the next is 6 cycles with 3 high. oPending clears at the boundary.
- iLoad iPeriod = 0, iHigh = 9 → clamped to P = 2, H = 2 → constant high. iLoad iPeriod = 12000 → P = 10000.
- P = 8, H = 4, iCE toggling 1,0 → each oSignal level lasts 8 clocks and the period lasts 16 clocks. oWrap is one clock wide.
- iRun dropped at tick 2 of P = 6 → remaining ticks complete, then IDLE. oSignal = 0 and oBusy = 0 one cycle after oWrap's triggering tick.
- iRst asserted mid-period with a load pending → next cycle all outputs 0, oPending = 0. Restart uses P = 10000, H = 0.
